// File: rtl/pp_scoreboard_pkg.sv
// Shared constants and helpers for the hv pipeline register scoreboard.
// Holds the bypass-select base and the core's default depth/register count.
package pp_scoreboard_pkg;

    // fwd_sel value meaning "read from the register file"
    localparam int unsigned PP_SB_SEL_RF     = 0;
    // Defaults match the core's 4-cycle decode-to-writeback delay
    localparam int unsigned PP_SB_DEPTH_DEF  = 4;
    localparam int unsigned PP_SB_NREGS_DEF  = 16;
    localparam int unsigned PP_SB_MAX_DEPTH  = 8;

    function automatic int unsigned pp_sb_popcount(input logic [PP_SB_MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < PP_SB_MAX_DEPTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/pp_sb_match.sv
// Youngest-match priority finder for one source read port.
// Returns whether any valid stage writes the requested index, and the lowest such stage.
module pp_sb_match
    import pp_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = PP_SB_DEPTH_DEF,
    parameter int unsigned RIDX_W = 4,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                      ren,
    input  logic [RIDX_W-1:0]         src_idx,
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH*RIDX_W-1:0]   stage_idx,
    output logic                      hit,
    output logic [SEL_W-1:0]          stage
);

    always_comb begin
        hit   = 1'b0;
        stage = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (!hit && ren && valid[s] && (stage_idx[s*RIDX_W +: RIDX_W] == src_idx)) begin
                hit   = 1'b1;
                stage = SEL_W'(s);
            end
        end
    end

endmodule

// File: rtl/pp_scoreboard.sv
// Register scoreboard / hazard controller: tracks in-flight GPR writes and stalls decode.
// Define PP_SB_FWD_EN to turn late-stage matches into operand bypass selects instead of stalls.
module pp_scoreboard
    import pp_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS     = PP_SB_NREGS_DEF,
    parameter int unsigned RIDX_W    = 4,
    parameter int unsigned DEPTH     = PP_SB_DEPTH_DEF,
    parameter int unsigned NSRC      = 3,
    parameter int unsigned FWD_STAGE = 2,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid_i,
    input  logic [NSRC-1:0]         src_ren_i,
    input  logic [NSRC*RIDX_W-1:0]  src_idx_i,
    input  logic                    dst_wen_i,
    input  logic [RIDX_W-1:0]       dst_idx_i,
    input  logic                    hold_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic                    issue_o,
    output logic [NSRC*SEL_W-1:0]   fwd_sel_o,
    output logic [NREGS-1:0]        busy_o,
    output logic [SEL_W-1:0]        inflight_o
);

`ifdef PP_SB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    // Without bypass the threshold sits past the last stage, so every match stalls
    localparam logic [SEL_W-1:0] FWD_MIN = SEL_W'(FWD_EN ? FWD_STAGE : DEPTH);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH*RIDX_W-1:0] idx_q;
    logic [NSRC-1:0]         hit;
    logic [SEL_W-1:0]        stage [NSRC];
    logic                    conflict;

    for (genvar k = 0; k < NSRC; k++) begin : g_match
        pp_sb_match #(
            .DEPTH  (DEPTH),
            .RIDX_W (RIDX_W),
            .SEL_W  (SEL_W)
        ) u_match (
            .ren       (src_ren_i[k]),
            .src_idx   (src_idx_i[k*RIDX_W +: RIDX_W]),
            .valid     (valid_q),
            .stage_idx (idx_q),
            .hit       (hit[k]),
            .stage     (stage[k])
        );
    end

    always_comb begin
        conflict  = 1'b0;
        fwd_sel_o = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            fwd_sel_o[k*SEL_W +: SEL_W] = SEL_W'(PP_SB_SEL_RF);
            if (hit[k]) begin
                if (stage[k] >= FWD_MIN) begin
                    fwd_sel_o[k*SEL_W +: SEL_W] = stage[k] + SEL_W'(1);
                end else begin
                    conflict = 1'b1;
                end
            end
        end
    end

    assign stall_o = hold_i | (issue_valid_i & conflict);
    assign issue_o = issue_valid_i & ~stall_o & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (!hold_i) begin
            for (int unsigned s = 1; s < DEPTH; s++) begin
                valid_q[s]                  <= valid_q[s-1];
                idx_q[s*RIDX_W +: RIDX_W]   <= idx_q[(s-1)*RIDX_W +: RIDX_W];
            end
            valid_q[0]        <= issue_o & dst_wen_i;
            idx_q[0 +: RIDX_W] <= dst_idx_i;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (valid_q[s]) busy_o[idx_q[s*RIDX_W +: RIDX_W]] = 1'b1;
        end
    end

    assign inflight_o = SEL_W'(pp_sb_popcount(PP_SB_MAX_DEPTH'(valid_q)));

endmodule
